// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (a - b), LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_aMsb;
  logic             r_bMsb;
  logic             r_ovf;
`endif

  logic w_d;
  logic w_brNext;
  logic w_lastBit;

  assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
  assign w_brNext  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  assign w_lastBit = (r_cnt == CW'(WIDTH - 1));

  // busy/done are flops fed from the state, so they lag it by one cycle and never overlap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_aMsb   <= 1'b0;
      r_bMsb   <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_busy <= (r_state == S_RUN);
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_aMsb  <= a[WIDTH-1];
            r_bMsb  <= b[WIDTH-1];
`endif
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_br  <= w_brNext;
          r_cnt <= r_cnt + CW'(1);
          if (w_lastBit) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_diff   <= r_res;
          r_borrow <= r_br;
`ifdef SERIAL_SUB_OVF_EN
          r_ovf    <= (r_aMsb != r_bMsb) && (r_res[WIDTH-1] != r_aMsb);
`endif
          // A start seen here reloads immediately for back-to-back throughput
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_aMsb  <= a[WIDTH-1];
            r_bMsb  <= b[WIDTH-1];
`endif
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboard of expected results,
// one task per scenario. Define SERIAL_SUB_OVF_EN to also check ovf.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int   nVec = 0;
  int   nMis = 0;
  exp_t sbQ[$];
  exp_t held;

  logic [W-1:0] vecA [6] = '{8'd200, 8'd5,  8'd0, 8'd255, 8'h80, 8'h7F};
  logic [W-1:0] vecB [6] = '{8'd55,  8'd10, 8'd0, 8'd255, 8'h01, 8'hFF};

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  // Reference arithmetic straight from the definition of a - b
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.diff   = x - y;
    e.borrow = (x < y);
    e.ovf    = (x[W-1] != y[W-1]) && (e.diff[W-1] != x[W-1]);
    return e;
  endfunction

  // Drives one start pulse; returns at the first falling edge after the sampling edge
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a     = x;
    b     = y;
    start = 1'b1;
    sbQ.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    nVec++; if (busy !== 1'b0) begin nMis++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    nVec++; if (done !== 1'b0) begin nMis++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    nVec++; if (diff !== '0) begin nMis++; $display("[TB] FAIL reset_diff: got %0d expected 0", diff); end
    nVec++; if (borrow !== 1'b0) begin nMis++; $display("[TB] FAIL reset_borrow: got %b expected 0", borrow); end
`ifdef SERIAL_SUB_OVF_EN
    nVec++; if (ovf !== 1'b0) begin nMis++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nVec++; if (busy !== 1'b0 || done !== 1'b0) begin nMis++; $display("[TB] FAIL post_reset_idle: got busy=%b done=%b expected 0 0", busy, done); end
    held = '{diff: '0, borrow: 1'b0, ovf: 1'b0};
  endtask

  task automatic test_vectors;
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecA[v], vecB[v]);
      nVec++; if (busy !== 1'b0 || done !== 1'b0) begin nMis++; $display("[TB] FAIL vec%0d_k0: got busy=%b done=%b expected 0 0", v, busy, done); end
      for (int k = 1; k <= W + 6; k++) begin
        @(negedge clk);
        nVec++; if (busy !== (k <= W)) begin nMis++; $display("[TB] FAIL vec%0d_busy k=%0d: got %b expected %b", v, k, busy, (k <= W)); end
        nVec++; if (done !== (k == W + 1)) begin nMis++; $display("[TB] FAIL vec%0d_done k=%0d: got %b expected %b", v, k, done, (k == W + 1)); end
        if (k == W + 1) held = sbQ.pop_front();
        nVec++; if (diff !== held.diff) begin nMis++; $display("[TB] FAIL vec%0d_diff k=%0d: got %0d expected %0d", v, k, diff, held.diff); end
        nVec++; if (borrow !== held.borrow) begin nMis++; $display("[TB] FAIL vec%0d_borrow k=%0d: got %b expected %b", v, k, borrow, held.borrow); end
`ifdef SERIAL_SUB_OVF_EN
        nVec++; if (ovf !== held.ovf) begin nMis++; $display("[TB] FAIL vec%0d_ovf k=%0d: got %b expected %b", v, k, ovf, held.ovf); end
`endif
      end
    end
  endtask

  task automatic test_start_in_run;
    int doneCnt;
    doneCnt = 0;
    applyStimulus(8'd100, 8'd1);
    for (int k = 1; k <= W + 5; k++) begin
      @(negedge clk);
      if (k == 3) begin
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) doneCnt++;
      if (k == W + 1) begin
        held = sbQ.pop_front();
        nVec++; if (done !== 1'b1) begin nMis++; $display("[TB] FAIL run_start_done: got %b expected 1", done); end
        nVec++; if (diff !== held.diff) begin nMis++; $display("[TB] FAIL run_start_diff: got %0d expected %0d", diff, held.diff); end
      end
    end
    nVec++; if (doneCnt != 1) begin nMis++; $display("[TB] FAIL run_start_done_count: got %0d expected 1", doneCnt); end
  endtask

  task automatic test_reset_mid;
    int  waitCnt;
    bit  seen;
    applyStimulus(8'd50, 8'd20);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nVec++; if (busy !== 1'b0) begin nMis++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    nVec++; if (diff !== '0) begin nMis++; $display("[TB] FAIL midrst_diff: got %0d expected 0", diff); end
    nVec++; if (borrow !== 1'b0) begin nMis++; $display("[TB] FAIL midrst_borrow: got %b expected 0", borrow); end
    sbQ.delete();
    held = '{diff: '0, borrow: 1'b0, ovf: 1'b0};
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    nVec++; if (seen) begin nMis++; $display("[TB] FAIL midrst_no_done: got activity expected none"); end
    applyStimulus(8'd20, 8'd7);
    waitCnt = 0;
    while (done !== 1'b1 && waitCnt < W + 4) begin
      @(negedge clk);
      waitCnt++;
    end
    nVec++;
    if (done !== 1'b1) begin
      nMis++; $display("[TB] FAIL midrst_restart_timeout: got no done expected done within %0d cycles", W + 4);
    end else begin
      held = sbQ.pop_front();
      if (diff !== held.diff || borrow !== held.borrow) begin
        nMis++; $display("[TB] FAIL midrst_restart_result: got %0d/%b expected %0d/%b", diff, borrow, held.diff, held.borrow);
      end
    end
    sbQ.delete();
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    a     = 8'd10;
    b     = 8'd3;
    start = 1'b1;
    sbQ.push_back(model(8'd10, 8'd3));
    @(negedge clk);
    a = 8'd3;
    b = 8'd10;
    sbQ.push_back(model(8'd3, 8'd10));
    for (int k = 1; k <= 2 * W + 5; k++) begin
      @(negedge clk);
      if (k == W + 1) start = 1'b0;
      nVec++; if (busy !== ((k >= 1 && k <= W) || (k >= W + 2 && k <= 2 * W + 1))) begin nMis++; $display("[TB] FAIL b2b_busy k=%0d: got %b", k, busy); end
      nVec++; if (done !== (k == W + 1 || k == 2 * W + 2)) begin nMis++; $display("[TB] FAIL b2b_done k=%0d: got %b", k, done); end
      if (k == W + 1 || k == 2 * W + 2) begin
        if (sbQ.size() > 0) held = sbQ.pop_front();
        nVec++; if (diff !== held.diff) begin nMis++; $display("[TB] FAIL b2b_diff k=%0d: got %0d expected %0d", k, diff, held.diff); end
        nVec++; if (borrow !== held.borrow) begin nMis++; $display("[TB] FAIL b2b_borrow k=%0d: got %b expected %b", k, borrow, held.borrow); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_vectors();
    test_start_in_run();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
